fwht_sequencer: RTL and testbench
=================================

Name: fwht_sequencer

Overview:
- Sequencer that time-multiplexes one combinational butterfly datapath to compute an N-point in-place Fast Walsh-Hadamard Transform on complex samples.
- Butterfly computes c = a + b and d = a - b.
- Three phases: load N samples over a val/rdy stream, run log2(N) butterfly stages on an internal register buffer, stream N results out in natural Hadamard order.
- Sits between a sample source (e.g. deserializer) and downstream spectral/classification logic.

Parameters:
- BITWIDTH, 32, width of each real and imaginary component (two's complement).
- N, 8, transform length; power of two, N >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- recv_msg_r  input  BITWIDTH  input sample, real part.
- recv_msg_c  input  BITWIDTH  input sample, imaginary part.
- recv_val  input  1  input sample valid.
- recv_rdy  output  1  block accepts an input sample.
- send_msg_r  output  BITWIDTH  output coefficient, real part.
- send_msg_c  output  BITWIDTH  output coefficient, imaginary part.
- send_val  output  1  output coefficient valid.
- send_rdy  input  1  downstream accepts the coefficient.
- busy  output  1  high in COMPUTE state.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset_n).
- Reset (reset_n=0, any time, including mid-load, mid-compute or mid-unload):
  - state=LOAD; all counters=0; buffer entries cleared to 0.
  - Outputs: recv_rdy=1 after reset, send_val=0, busy=0, send_msg_r/c=0.
  - A partial frame is discarded.
- State LOAD:
  - recv_rdy=1.
  - Each cycle with recv_val&recv_rdy writes buf[idx] <= {recv_msg_r, recv_msg_c}, then idx++.
  - When idx reaches N-1 and that sample is accepted: go to COMPUTE next cycle, idx=0.
  - recv_val=0 simply stalls; no timeout.
- State COMPUTE:
  - recv_rdy=0, send_val=0, busy=1.
  - Counters: stage s in 0..log2(N)-1; butterfly k in 0..N/2-1. Span h=2^s.
  - Operand indices: i = ((k>>s)<<(s+1)) | (k & (h-1)), j = i+h.
  - One butterfly per cycle. Operands buf[i] and buf[j] are read combinationally; results are written back on the same edge: buf[i] <= buf[i]+buf[j], buf[j] <= buf[i]-buf[j].
  - Real and imaginary parts are processed independently.
  - k wraps to 0 and s increments after k=N/2-1.
  - After s=log2(N)-1, k=N/2-1: go to UNLOAD, idx=0.
  - Compute latency is exactly (N/2)*log2(N) cycles (N=8: 12 cycles).
- State UNLOAD:
  - send_val=1; send_msg = buf[idx].
  - idx++ on send_val&send_rdy.
  - While send_rdy=0, send_msg and idx hold stable.
  - Handshake on idx=N-1: go to LOAD next cycle.
  - recv_rdy=0 throughout; no overlap of frames.
- Arithmetic: BITWIDTH-bit two's complement, modular wrap on overflow, no saturation. Caller provides headroom (log2(N) bits of growth).
- send_msg_r/c are 0 whenever send_val=0.
- Total frame latency (last input accepted to first send_val) is (N/2)*log2(N) cycles, counting from the cycle after the last load handshake.

Optional Feature:
- Macro: FWHT_SCALE_EN.
- Defined: each butterfly result is arithmetic-shifted right by 1 before write-back (floor division by 2 per stage). Outputs equal the transform divided by N, with no growth. Sign bit is preserved.
- Undefined: unscaled results, modular wrap as above.
- Timing and handshakes are identical in both builds.

Test Plan:
- N=8, BITWIDTH=32, FWHT_SCALE_EN undefined, unless a scenario states otherwise.
- DC: load real=1, imag=0 for all 8 samples -> outputs real [8,0,0,0,0,0,0,0], imag all 0; first send_val exactly 12 cycles after the last load handshake.
- Impulse: x[3]=1+2j, all other samples 0 -> real [1,-1,-1,1,1,-1,-1,1], imag [2,-2,-2,2,2,-2,-2,2].
- Backpressure: hold send_rdy=0 for 5 cycles mid-unload at idx=4 -> send_msg stays stable at y[4]. With recv_val=1 throughout, recv_rdy stays 0 until all 8 outputs are taken; a new frame then loads correctly.
- Wrap: BITWIDTH=8, all real inputs 127 -> y[0] real = 0xF8 (-8), others 0.
- Reset mid-compute: assert reset_n=0 during stage 1 -> outputs cleared immediately, recv_rdy=1 after release; the next full frame (DC test) produces the correct result.
- Scale build (FWHT_SCALE_EN defined): DC frame with value 1 -> y=[1,0,0,0,0,0,0,0]. Single sample x[0]=-8 -> all outputs -1.

Source files
------------

// File: rtl/fwht_sequencer.sv
// In-place N-point Fast Walsh-Hadamard Transform on complex samples, one butterfly per cycle.
// Optional build macro FWHT_SCALE_EN: halve every butterfly result (outputs = transform / N).

module fwht_bfly #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_c,
  output logic [W-1:0] o_d
);
`ifdef FWHT_SCALE_EN
  // One extra bit so the halved result never loses the carry/sign.
  logic [W:0] w_sum, w_dif;
  assign w_sum = {i_a[W-1], i_a} + {i_b[W-1], i_b};
  assign w_dif = {i_a[W-1], i_a} - {i_b[W-1], i_b};
  assign o_c   = w_sum[W:1];
  assign o_d   = w_dif[W:1];
`else
  assign o_c = i_a + i_b;
  assign o_d = i_a - i_b;
`endif
endmodule

module fwht_sequencer #(
  parameter int BITWIDTH = 32,
  parameter int N        = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [BITWIDTH-1:0] recv_msg_r,
  input  logic [BITWIDTH-1:0] recv_msg_c,
  input  logic                recv_val,
  output logic                recv_rdy,
  output logic [BITWIDTH-1:0] send_msg_r,
  output logic [BITWIDTH-1:0] send_msg_c,
  output logic                send_val,
  input  logic                send_rdy,
  output logic                busy
);
  localparam int LOG2N = $clog2(N);
  localparam int IW    = LOG2N;
  localparam int KW    = (N > 2) ? $clog2(N / 2) : 1;
  localparam int SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1;

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

  state_t r_state, w_state_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [KW-1:0] r_k, w_k_nxt;
  logic [SW-1:0] r_stage, w_stage_nxt;
  logic          w_load_we, w_bfly_we;

  // Lane 1 = real, lane 0 = imaginary.
  logic [N-1:0][1:0][BITWIDTH-1:0] r_buf;
  logic [1:0][BITWIDTH-1:0]        w_c, w_d;

  logic [IW-1:0] w_kx, w_h, w_i, w_j;
  logic [SW:0]   w_s1;

  assign w_kx = IW'(r_k);
  assign w_s1 = {1'b0, r_stage} + (SW+1)'(1);
  assign w_h  = IW'(1) << r_stage;
  assign w_i  = ((w_kx >> r_stage) << w_s1) | (w_kx & (w_h - IW'(1)));
  assign w_j  = w_i + w_h;

  for (genvar l = 0; l < 2; l++) begin : g_lane
    fwht_bfly #(.W(BITWIDTH)) u_bfly (
      .i_a (r_buf[w_i][l]),
      .i_b (r_buf[w_j][l]),
      .o_c (w_c[l]),
      .o_d (w_d[l])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_k_nxt     = r_k;
    w_stage_nxt = r_stage;
    w_load_we   = 1'b0;
    w_bfly_we   = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (recv_val) begin
          w_load_we = 1'b1;
          if (r_idx == IW'(N - 1)) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_COMPUTE;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end
      end
      S_COMPUTE: begin
        w_bfly_we = 1'b1;
        if (r_k == KW'(N / 2 - 1)) begin
          w_k_nxt = '0;
          if (r_stage == SW'(LOG2N - 1)) begin
            w_stage_nxt = '0;
            w_idx_nxt   = '0;
            w_state_nxt = S_UNLOAD;
          end else begin
            w_stage_nxt = r_stage + SW'(1);
          end
        end else begin
          w_k_nxt = r_k + KW'(1);
        end
      end
      S_UNLOAD: begin
        if (send_rdy) begin
          if (r_idx == IW'(N - 1)) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_LOAD;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_LOAD;
      r_idx   <= '0;
      r_k     <= '0;
      r_stage <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_k     <= w_k_nxt;
      r_stage <= w_stage_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf <= '0;
    end else if (w_load_we) begin
      r_buf[r_idx] <= {recv_msg_r, recv_msg_c};
    end else if (w_bfly_we) begin
      r_buf[w_i] <= w_c;
      r_buf[w_j] <= w_d;
    end
  end

  assign recv_rdy   = (r_state == S_LOAD);
  assign busy       = (r_state == S_COMPUTE);
  assign send_val   = (r_state == S_UNLOAD);
  assign send_msg_r = send_val ? r_buf[r_idx][1] : '0;
  assign send_msg_c = send_val ? r_buf[r_idx][0] : '0;
endmodule

// File: tb/tb_fwht_sequencer.sv
// Bench for fwht_sequencer: directed + random frames against a Hadamard-matrix reference model.
module tb_fwht_sequencer;
  localparam int N  = 8;
  localparam int BW = 32;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [BW-1:0] recv_msg_r, recv_msg_c, send_msg_r, send_msg_c;
  logic          recv_val, recv_rdy, send_val, send_rdy, busy;

  logic [7:0] recv_msg_r8, recv_msg_c8, send_msg_r8, send_msg_c8;
  logic       recv_val8, recv_rdy8, send_val8, send_rdy8, busy8;

  fwht_sequencer #(.BITWIDTH(BW), .N(N)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .recv_msg_r(recv_msg_r), .recv_msg_c(recv_msg_c), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_msg_r(send_msg_r), .send_msg_c(send_msg_c), .send_val(send_val), .send_rdy(send_rdy),
    .busy(busy)
  );

  fwht_sequencer #(.BITWIDTH(8), .N(N)) u_dut8 (
    .clk(clk), .reset_n(reset_n),
    .recv_msg_r(recv_msg_r8), .recv_msg_c(recv_msg_c8), .recv_val(recv_val8), .recv_rdy(recv_rdy8),
    .send_msg_r(send_msg_r8), .send_msg_c(send_msg_c8), .send_val(send_val8), .send_rdy(send_rdy8),
    .busy(busy8)
  );

  int checks   = 0;
  int failures = 0;

  logic signed [31:0] xr[N], xc[N], er[N], ec[N];

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: y[k] = sum_n x[n] * (-1)^popcount(k&n); scaled build halves after each stage.
  function automatic void model();
`ifndef FWHT_SCALE_EN
    for (int k = 0; k < N; k++) begin
      logic signed [31:0] sr, sc;
      sr = 0; sc = 0;
      for (int n = 0; n < N; n++) begin
        if ($countones(k & n) % 2 == 1) begin sr = sr - xr[n]; sc = sc - xc[n]; end
        else begin sr = sr + xr[n]; sc = sc + xc[n]; end
      end
      er[k] = sr; ec[k] = sc;
    end
`else
    for (int n = 0; n < N; n++) begin er[n] = xr[n]; ec[n] = xc[n]; end
    for (int h = 1; h < N; h = h * 2)
      for (int b = 0; b < N; b += 2 * h)
        for (int t = b; t < b + h; t++) begin
          longint ar, br, ac, bc;
          ar = er[t]; br = er[t+h]; ac = ec[t]; bc = ec[t+h];
          er[t] = 32'((ar + br) >>> 1); er[t+h] = 32'((ar - br) >>> 1);
          ec[t] = 32'((ac + bc) >>> 1); ec[t+h] = 32'((ac - bc) >>> 1);
        end
`endif
  endfunction

  task automatic load_frame();
    for (int n = 0; n < N; n++) begin
      int guard;
      if ($urandom_range(3) == 0) begin
        recv_val = 1'b0;
        @(posedge clk); #1;
      end
      recv_val = 1'b1; recv_msg_r = xr[n]; recv_msg_c = xc[n];
      guard = 0;
      while (!recv_rdy && guard < 100) begin @(posedge clk); #1; guard++; end
      if (guard >= 100) chk("load_timeout", 0, 1);
      @(posedge clk); #1;
    end
    recv_val = 1'b0;
  endtask

  task automatic run_frame(input int stall_at);
    int cnt, idx, guard;
    bit stalled;
    model();
    load_frame();
    chk("busy_compute", busy, 1);
    chk("rdy_compute", recv_rdy, 0);
    cnt = 0;
    while (!send_val && cnt < 40) begin @(posedge clk); #1; cnt++; end
    chk("latency", cnt, 12);
    idx = 0; guard = 0; stalled = 0;
    if (stall_at >= 0) recv_val = 1'b1;
    while (idx < N && guard < 1000) begin
      if (idx == stall_at && !stalled) begin
        send_rdy = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          chk("bp_msg_r", $signed(send_msg_r), er[stall_at]);
          chk("bp_msg_c", $signed(send_msg_c), ec[stall_at]);
          chk("bp_recv_rdy", recv_rdy, 0);
        end
        stalled = 1;
      end
      send_rdy = ($urandom_range(3) != 0);
      chk("unload_recv_rdy", recv_rdy, 0);
      if (send_val && send_rdy) begin
        chk($sformatf("y_r[%0d]", idx), $signed(send_msg_r), er[idx]);
        chk($sformatf("y_c[%0d]", idx), $signed(send_msg_c), ec[idx]);
        idx++;
      end
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 1000) chk("unload_timeout", 0, 1);
    recv_val = 1'b0; send_rdy = 1'b0;
    chk("post_send_val", send_val, 0);
    chk("post_recv_rdy", recv_rdy, 1);
    chk("post_msg_r", send_msg_r, 0);
  endtask

  task automatic set_dc();
    for (int n = 0; n < N; n++) begin xr[n] = 1; xc[n] = 0; end
  endtask

  initial begin
    reset_n = 1'b0;
    recv_val = 0; recv_msg_r = 0; recv_msg_c = 0; send_rdy = 0;
    recv_val8 = 0; recv_msg_r8 = 0; recv_msg_c8 = 0; send_rdy8 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_recv_rdy", recv_rdy, 1);
    chk("rst_send_val", send_val, 0);
    chk("rst_busy", busy, 0);
    chk("rst_msg_r", send_msg_r, 0);
    chk("rst_msg_c", send_msg_c, 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // DC frame
    set_dc();
    run_frame(-1);
`ifndef FWHT_SCALE_EN
    chk("dc_y0_const", er[0], 8);
`else
    chk("dc_y0_const", er[0], 1);
`endif

    // Impulse at x[3] = 1+2j
    for (int n = 0; n < N; n++) begin xr[n] = 0; xc[n] = 0; end
    xr[3] = 1; xc[3] = 2;
    run_frame(-1);

    // Random frames, one with mid-unload backpressure at idx 4
    for (int f = 0; f < 3; f++) begin
      for (int n = 0; n < N; n++) begin xr[n] = $urandom; xc[n] = $urandom; end
      run_frame(f == 0 ? 4 : -1);
    end

`ifdef FWHT_SCALE_EN
    for (int n = 0; n < N; n++) begin xr[n] = 0; xc[n] = 0; end
    xr[0] = -8;
    run_frame(-1);
    chk("scale_neg_y7", er[7], -1);
`endif

    // Reset during stage 1 of compute
    set_dc();
    load_frame();
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_recv_rdy", recv_rdy, 1);
    chk("mid_rst_send_val", send_val, 0);
    chk("mid_rst_msg_r", send_msg_r, 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    set_dc();
    run_frame(-1);

    // 8-bit wrap: all real inputs 127
    begin
      int guard;
      chk("w8_recv_rdy", recv_rdy8, 1);
      recv_val8 = 1'b1; recv_msg_r8 = 8'd127; recv_msg_c8 = 8'd0;
      repeat (N) begin @(posedge clk); #1; end
      recv_val8 = 1'b0; send_rdy8 = 1'b1;
      guard = 0;
      while (!send_val8 && guard < 40) begin @(posedge clk); #1; guard++; end
      chk("w8_latency", guard, 12);
      for (int k = 0; k < N; k++) begin
`ifndef FWHT_SCALE_EN
        chk($sformatf("w8_y_r[%0d]", k), $signed(send_msg_r8), (k == 0) ? -8 : 0);
`else
        chk($sformatf("w8_y_r[%0d]", k), $signed(send_msg_r8), (k == 0) ? 127 : 0);
`endif
        chk($sformatf("w8_y_c[%0d]", k), $signed(send_msg_c8), 0);
        @(posedge clk); #1;
      end
      chk("w8_done", send_val8, 0);
      send_rdy8 = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
